// File: rtl/serializer_pkg.sv
// Shared types and constants for the word serializer.
package serializer_pkg;

    localparam int unsigned SER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a valid/ready
// handshake and streams it one bit per cycle on dout/dout_valid.
// Optional feature: define WORD_SERIALIZER_PARITY_EN to append an
// even-parity bit after the data bits.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int unsigned    CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             last_bit;
    logic             final_cycle;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shift_rest;

    // Last data bit is on the wire; with parity the PAR cycle ends the word instead.
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`ifdef WORD_SERIALIZER_PARITY_EN
    assign final_cycle = (state_q == PAR);
`else
    assign final_cycle = last_bit;
`endif

    assign s_ready = (state_q == IDLE) || final_cycle;
    assign accept  = s_valid && s_ready;

    // Bit selection and shift direction for the configured bit order.
    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit  = s_data[WIDTH-1];
            load_rest  = {s_data[WIDTH-2:0], 1'b0};
            next_bit   = shreg_q[WIDTH-1];
            shift_rest = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            first_bit  = s_data[0];
            load_rest  = {1'b0, s_data[WIDTH-1:1]};
            next_bit   = shreg_q[0];
            shift_rest = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state, counter, shift register and next output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        par_d        = par_q;
`endif

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    shreg_d      = shift_rest;
                    dout_d       = next_bit;
                    dout_valid_d = 1'b1;
                end else begin
                    cnt_d = '0;
`ifdef WORD_SERIALIZER_PARITY_EN
                    state_d      = PAR;
                    dout_d       = par_q;
                    dout_valid_d = 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PAR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new word loads from IDLE or from the final cycle with no gap.
        if (accept) begin
            state_d      = SHIFT;
            cnt_d        = '0;
            shreg_d      = load_rest;
            dout_d       = first_bit;
            dout_valid_d = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_d        = ^s_data;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one MSB-first and one LSB-first instance,
// table-driven single words plus back-to-back, mid-word reset and idle sequences.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int WLEN = 8 + PAR_EN;

    logic       clk;
    logic       reset;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic       m_ready, l_ready;
    logic       m_dout, l_dout;
    logic       m_dv, l_dv;
    logic       m_busy, l_busy;

    logic       sel;
    logic       cur_ready, cur_dout, cur_dv, cur_busy;

    int n_total = 0;
    int n_pass  = 0;

    word_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .s_data(m_data), .s_valid(m_valid),
        .s_ready(m_ready), .dout(m_dout), .dout_valid(m_dv), .busy(m_busy)
    );

    word_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .s_data(l_data), .s_valid(l_valid),
        .s_ready(l_ready), .dout(l_dout), .dout_valid(l_dv), .busy(l_busy)
    );

    assign cur_ready = sel ? m_ready : l_ready;
    assign cur_dout  = sel ? m_dout  : l_dout;
    assign cur_dv    = sel ? m_dv    : l_dv;
    assign cur_busy  = sel ? m_busy  : l_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d passed=%0d", n_total, n_pass);
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       msb;
        logic [7:0] bits;   // bits[7] is the first bit on the wire
        logic       par;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin
            m_valid = v;
            m_data  = d;
        end else begin
            l_valid = v;
            l_data  = d;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, ".dv"},    32'(cur_dv),    32'd0);
        check({name, ".dout"},  32'(cur_dout),  32'd0);
        check({name, ".busy"},  32'(cur_busy),  32'd0);
        check({name, ".ready"}, 32'(cur_ready), 32'd1);
    endtask

    // Sends one word, keeps junk on s_data/s_valid while not ready, checks each bit.
    task automatic send_word(input vec_t v);
        logic exp_bit;
        sel = v.msb;
        @(negedge clk);
        check({v.name, ".ready_pre"}, 32'(cur_ready), 32'd1);
        drive(1'b1, v.data);
        @(posedge clk);
        #1;
        drive(1'b1, ~v.data);
        for (int i = 0; i < WLEN; i++) begin
            @(negedge clk);
            exp_bit = (i < 8) ? v.bits[7-i] : v.par;
            check($sformatf("%s.dv[%0d]", v.name, i),    32'(cur_dv),    32'd1);
            check($sformatf("%s.bit[%0d]", v.name, i),   32'(cur_dout),  32'(exp_bit));
            check($sformatf("%s.busy[%0d]", v.name, i),  32'(cur_busy),  32'd1);
            check($sformatf("%s.ready[%0d]", v.name, i), 32'(cur_ready), 32'(i == WLEN - 1));
            if (i == WLEN - 1) drive(1'b0, 8'h00);
        end
        @(negedge clk);
        check_idle({v.name, ".after"});
    endtask

    logic exp_stream[2*WLEN];

    initial begin
        vecs[0] = '{"b0_msb",  8'hB0, 1'b1, 8'b1011_0000, 1'b1};
        vecs[1] = '{"0d_lsb",  8'h0D, 1'b0, 8'b1011_0000, 1'b1};
        vecs[2] = '{"ff_msb",  8'hFF, 1'b1, 8'b1111_1111, 1'b0};
        vecs[3] = '{"01_msb",  8'h01, 1'b1, 8'b0000_0001, 1'b1};
        vecs[4] = '{"01_lsb",  8'h01, 1'b0, 8'b1000_0000, 1'b1};
        vecs[5] = '{"a5_lsb",  8'hA5, 1'b0, 8'b1010_0101, 1'b0};
        vecs[6] = '{"03_msb",  8'h03, 1'b1, 8'b0000_0011, 1'b0};

        reset = 1'b1;
        m_data = 8'h00; l_data = 8'h00; m_valid = 1'b0; l_valid = 1'b0;
        sel = 1'b1;

        // Reset state on both instances.
        repeat (2) @(negedge clk);
        sel = 1'b1; check_idle("rst_msb");
        sel = 1'b0; check_idle("rst_lsb");
        reset = 1'b0;

        // Idle with s_valid low for 20 cycles.
        sel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle[%0d]", i));
        end

        // Table of single words.
        for (int k = 0; k < 7; k++) send_word(vecs[k]);

        // Back-to-back: B0 then FF with s_valid held high.
        for (int i = 0; i < 8; i++) begin
            exp_stream[i]        = vecs[0].bits[7-i];
            exp_stream[WLEN + i] = vecs[2].bits[7-i];
        end
        if (PAR_EN != 0) begin
            exp_stream[WLEN-1]   = 1'b1;
            exp_stream[2*WLEN-1] = 1'b0;
        end
        sel = 1'b1;
        @(negedge clk);
        m_valid = 1'b1; m_data = 8'hB0;
        @(posedge clk);
        #1 m_data = 8'hFF;
        for (int i = 0; i < 2*WLEN; i++) begin
            @(negedge clk);
            check($sformatf("b2b.dv[%0d]", i),  32'(m_dv),   32'd1);
            check($sformatf("b2b.bit[%0d]", i), 32'(m_dout), 32'(exp_stream[i]));
            if (i == WLEN - 1) begin
                check("b2b.second_accept_ready", 32'(m_ready), 32'd1);
                @(posedge clk);
                #1 m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_idle("b2b.after");

        // Reset on the 4th bit of B0, then a clean 0F.
        @(negedge clk);
        m_valid = 1'b1; m_data = 8'hB0;
        @(posedge clk);
        #1 m_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid.bit3", 32'(m_dout), 32'd1);
        check("rstmid.dv3",  32'(m_dv),   32'd1);
        reset = 1'b1;
        #1;
        check_idle("rstmid.now");
        @(negedge clk);
        check_idle("rstmid.hold");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle($sformatf("rstmid.post[%0d]", i));
        end
        send_word('{"0f_msb", 8'h0F, 1'b1, 8'b0000_1111, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 s_data  input  WIDTH  parallel word to serialize.
REQ-006 s_valid  input  1  s_data is valid.
REQ-007 s_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  1  serial bit stream, the din feed of the downstream sequence detector.
REQ-009 dout_valid  output  1  dout carries a live bit this cycle.
REQ-010 busy  output  1  a word is in flight (state not IDLE).

Function
REQ-011 A word SHALL be accepted only on a rising edge where s_valid && s_ready; the word is captured into an internal shift register.
REQ-012 The state machine SHALL have states IDLE, SHIFT and PAR (PAR exists only with PARITY_EN).
REQ-013 IDLE -> SHIFT on accept; SHIFT stays for WIDTH cycles; SHIFT -> PAR after the last bit (with PARITY_EN), otherwise SHIFT -> IDLE; PAR -> IDLE after one cycle.
REQ-014 At the end of the final phase (last SHIFT bit without PARITY_EN, PAR cycle with it), an accept SHALL re-enter SHIFT directly with no idle gap.
REQ-015 Latency: the first bit of an accepted word SHALL appear on dout, with dout_valid=1, in the cycle after the accept edge.
REQ-016 dout_valid SHALL be 1 for exactly WIDTH consecutive cycles per word (WIDTH+1 with PARITY_EN), and 0 otherwise.
REQ-017 Bit order SHALL follow MSB_FIRST, one bit per cycle, with no repeated or skipped bits.
REQ-018 s_ready SHALL be combinational: 1 in IDLE, and 1 in the final cycle of the final phase; 0 otherwise.
REQ-019 When dout_valid=0, dout SHALL be driven to 0.
REQ-020 s_data and s_valid changes SHALL have no effect while s_ready=0.
REQ-021 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL count 0..WIDTH-1 without wrapping past WIDTH-1.

Reset
REQ-022 Asserting reset SHALL immediately force state=IDLE, and clear the counter and the shift register to 0.
REQ-023 Asserting reset SHALL immediately drive dout=0, dout_valid=0 and busy=0; s_ready SHALL read 1 while reset is high.
REQ-024 Reset mid-word SHALL discard the in-flight word with no further bits emitted; the first accept after reset deassertion starts a fresh word.

Configuration
REQ-025 Macro WORD_SERIALIZER_PARITY_EN defined: after the last data bit, one PAR cycle emits the even-parity bit (XOR of all WIDTH data bits) with dout_valid=1.
REQ-026 Macro WORD_SERIALIZER_PARITY_EN undefined: the PAR state and parity logic are absent, and the word length is exactly WIDTH bits.

Structure
REQ-027 Package serializer_pkg SHALL hold the state enum typedef (ser_state_t: IDLE, SHIFT, PAR) and the default-width constant SER_WIDTH_DEFAULT=8.
REQ-028 The block is a single module with no sub-module; the shift register, counter and FSM are all inline.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, s_data=8'hB0 accepted -> dout = 1,0,1,1,0,0,0,0 on the 8 following cycles, with dout_valid high on those cycles only.
REQ-030 MSB_FIRST=0, s_data=8'h0D -> dout = 1,0,1,1,0,0,0,0; s_ready is low for the first 7 bit cycles.
REQ-031 8'hB0 then 8'hFF, with s_valid held high -> 16 contiguous dout_valid cycles, no gap, and the second accept occurs on the last-bit cycle of the first word.
REQ-032 PARITY_EN defined, 8'hB0 -> 8 data bits, then parity bit 1; 8'h03 -> parity bit 0; dout_valid high for 9 cycles.
REQ-033 reset asserted on the 4th bit of 8'hB0 -> dout and dout_valid go to 0 immediately; no further bits follow; the next word 8'h0F serializes cleanly.
REQ-034 s_valid held low for 20 cycles after reset -> dout_valid=0, dout=0, busy=0 and s_ready=1 throughout.
